pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter stage for the MIPS pipeline. Holds the PC register and generates the sequential PC+STEP.
- Selects the next PC from four sources: sequential, branch, jump and jump-register.
- Holds the PC on a pipeline stall. A redirect that arrives during a stall is buffered and applied when the stall releases.
- Sits ahead of instruction memory. Feeds pc/pc_plus into the IF/ID register; takes redirect requests from ID/EX.

Parameters:
- WIDTH, 32, PC/address width in bits (must be ≥ 32).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- STEP, 4, sequential increment in bytes.
- OFFSET_W, 16, width of the signed branch word offset.
- EXC_VECTOR, 32'h0000_0080, misalignment trap target (used only with PC_ALIGN_CHECK_EN).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC (load-use hazard / memory wait)
- branch_taken  in  1  branch redirect request
- branch_base  in  WIDTH  PC+STEP of the branch/jump instruction
- branch_offset  in  OFFSET_W  signed word offset
- jump  in  1  J/JAL redirect request
- jump_index  in  26  instruction index field
- jr  in  1  JR/JALR redirect request
- jr_target  in  WIDTH  register-sourced target
- pc  out  WIDTH  current fetch address (registered)
- pc_plus  out  WIDTH  pc + STEP (combinational from pc)
- redirected  out  1  one-cycle pulse: pc was loaded with a non-sequential target
- redirect_pending  out  1  a buffered redirect awaits stall release
- align_err  out  1  misaligned-target pulse (macro only; tied 0 otherwise)

Behaviour:
- Reset (sync, at clk edge with reset=1): pc=RESET_PC, redirected=0, redirect_pending=0, pending target=0, align_err=0. Reset overrides stall and all requests, including mid-stall with a pending redirect; the pending redirect is discarded.
- Target arithmetic (all modulo 2^WIDTH, wrap silently):
  - branch target = branch_base + (sign-extended branch_offset << 2)
  - jump target = {branch_base[WIDTH-1:28], jump_index, 2'b00}
  - jr target = jr_target
  - pc_plus = pc + STEP; e.g. 32'hFFFF_FFFC + 4 = 0.
- Request priority when several are asserted in one cycle: jr > jump > branch_taken.
- Next-state per clock edge (reset=0):
  - stall=0, new request: pc <= selected target; redirected=1 next cycle; any pending redirect is cleared (newest wins).
  - stall=0, no request, pending=1: pc <= pending target; redirected=1; pending cleared.
  - stall=0, no request, no pending: pc <= pc_plus; redirected=0.
  - stall=1, new request: pc holds; pending target <= selected target; redirect_pending=1 (overwrites an older pending entry); redirected=0.
  - stall=1, no request: pc and pending state hold; redirected=0.
- States: RUN (pending=0), HELD (pending=1). HELD→RUN on the first edge with stall=0 or reset.
- Latency: redirect request to pc update is 1 clk when unstalled. When stalled, it is the first edge after stall deasserts.
- redirected is registered; it is high exactly the cycle after the load.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN
- Defined: any target about to be loaded into pc (direct or from pending) with bits [1:0]≠0 is replaced by EXC_VECTOR. align_err pulses 1 for one cycle, aligned with redirected=1.
- Undefined: the target loads unmodified; align_err is constant 0.

Test Plan:
- Reset then 3 free-running clocks -> pc sequence 0,4,8,12; pc_plus=16; redirected=0.
- pc=32'h100, branch_taken=1, branch_base=32'h104, branch_offset=16'hFFFE -> next pc=32'hFC, redirected=1 for one cycle.
- stall=1 with jump=1, branch_base=32'h0040_0010, jump_index=26'h10_0000 for one cycle; stall held 3 more cycles -> pc frozen and redirect_pending=1; first edge after stall=0 loads pc=32'h0040_0000 and clears pending.
- jr=1, jump=1 and branch_taken=1 in the same cycle with jr_target=32'h2000 -> pc=32'h2000.
- pc forced near top (RESET_PC=32'hFFFF_FFF8), no requests -> sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With PC_ALIGN_CHECK_EN, jr_target=32'h2002 -> pc=32'h80 and align_err=1 for one cycle. Without the macro -> pc=32'h2002 and align_err=0.
- Reset asserted during stall with a pending redirect -> pc=RESET_PC and redirect_pending=0.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program-counter stage for the MIPS pipeline.
// Holds the fetch PC, produces PC+STEP and picks the next PC from the
// sequential, branch, jump and jump-register sources (jr > jump > branch).
// A redirect that arrives while stalled is parked and replayed on stall release.
// Optional build macro PC_ALIGN_CHECK_EN: misaligned targets are replaced by
// EXC_VECTOR and flagged on align_err.
module pc_unit #(
  parameter int                WIDTH      = 32,
  parameter logic [WIDTH-1:0]  RESET_PC   = 32'h0000_0000,
  parameter int                STEP       = 4,
  parameter int                OFFSET_W   = 16,
  parameter logic [WIDTH-1:0]  EXC_VECTOR = 32'h0000_0080
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [WIDTH-1:0]    branch_base,
  input  logic [OFFSET_W-1:0] branch_offset,
  input  logic                jump,
  input  logic [25:0]         jump_index,
  input  logic                jr,
  input  logic [WIDTH-1:0]    jr_target,
  output logic [WIDTH-1:0]    pc,
  output logic [WIDTH-1:0]    pc_plus,
  output logic                redirected,
  output logic                redirect_pending,
  output logic                align_err
);

  // Parameter sanity: address must hold the 28-bit jump region, the shifted
  // offset must fit, and the trap vector itself must be word aligned.
  if (WIDTH < 32 || OFFSET_W + 2 > WIDTH || EXC_VECTOR[1:0] != 2'b00) begin : g_bad_param
    $error("pc_unit: illegal parameter combination");
  end

  typedef enum logic {RUN, HELD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             redir_q, redir_d;
  logic             req;
  logic [WIDTH-1:0] br_tgt, j_tgt, sel_tgt, ld_tgt, ld_fix;
  logic             load, misaligned;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  assign pc_plus = pc_q + STEP_W;
  assign br_tgt  = branch_base + {{(WIDTH-OFFSET_W-2){branch_offset[OFFSET_W-1]}},
                                  branch_offset, 2'b00};
  assign j_tgt   = {branch_base[WIDTH-1:28], jump_index, 2'b00};
  assign req     = jr | jump | branch_taken;

  // Request priority: jr over jump over branch.
  always_comb begin
    sel_tgt = br_tgt;
    if (jr)        sel_tgt = jr_target;
    else if (jump) sel_tgt = j_tgt;
  end

  // Next-state: direct redirect, replay of the parked one, or sequential step.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pc_d    = pc_q;
    load    = 1'b0;
    ld_tgt  = pend_q;
    if (!stall) begin
      state_d = RUN;
      if (req) begin
        load   = 1'b1;
        ld_tgt = sel_tgt;
      end else if (state_q == HELD) begin
        load   = 1'b1;
        ld_tgt = pend_q;
      end else begin
        pc_d = pc_plus;
      end
    end else if (req) begin
      // Newest request wins over an older parked one.
      pend_d  = sel_tgt;
      state_d = HELD;
    end
    if (load) pc_d = ld_fix;
    redir_d = load;
  end

`ifdef PC_ALIGN_CHECK_EN
  logic align_q;
  assign misaligned = (ld_tgt[1:0] != 2'b00);
  assign ld_fix     = misaligned ? EXC_VECTOR : ld_tgt;
  assign align_err  = align_q;

  // Trap flag rides alongside redirected.
  always_ff @(posedge clk) begin
    if (reset) align_q <= 1'b0;
    else       align_q <= load & misaligned;
  end
`else
  assign misaligned = 1'b0;
  assign ld_fix     = ld_tgt;
  assign align_err  = misaligned;
`endif

  // State, PC, parked target and redirect pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      redir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      redir_q <= redir_d;
    end
  end

  assign pc               = pc_q;
  assign redirected       = redir_q;
  assign redirect_pending = (state_q == HELD);

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes the expected post-edge state,
// a negedge monitor pops and compares. A second instance covers PC wrap.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, reset2, stall, branch_taken, jump, jr;
  logic [31:0] branch_base, jr_target;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus, pc2, pc_plus2;
  logic        redirected, redirect_pending, align_err;
  logic        redirected2, redirect_pending2, align_err2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_ON = 1'b1;
`else
  localparam bit ALIGN_ON = 1'b0;
`endif

  typedef struct {
    int          cyc;
    bit          which;
    logic [31:0] pc;
    logic        red;
    logic        pend;
    logic        al;
    string       nm;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_base(branch_base), .branch_offset(branch_offset), .jump(jump),
    .jump_index(jump_index), .jr(jr), .jr_target(jr_target),
    .pc(pc), .pc_plus(pc_plus), .redirected(redirected),
    .redirect_pending(redirect_pending), .align_err(align_err)
  );

  pc_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_top (
    .clk(clk), .reset(reset2), .stall(1'b0), .branch_taken(1'b0),
    .branch_base(32'h0), .branch_offset(16'h0), .jump(1'b0),
    .jump_index(26'h0), .jr(1'b0), .jr_target(32'h0),
    .pc(pc2), .pc_plus(pc_plus2), .redirected(redirected2),
    .redirect_pending(redirect_pending2), .align_err(align_err2)
  );

  // Monitor: compare every expectation due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] a_pc, a_pp;
      logic a_red, a_pend, a_al;
      e = q.pop_front();
      if (e.which) begin
        a_pc = pc2; a_pp = pc_plus2; a_red = redirected2; a_pend = redirect_pending2; a_al = align_err2;
      end else begin
        a_pc = pc; a_pp = pc_plus; a_red = redirected; a_pend = redirect_pending; a_al = align_err;
      end
      tests++;
      if (e.cyc != cyc || a_pc !== e.pc || a_pp !== e.pc + 32'd4 || a_red !== e.red ||
          a_pend !== e.pend || a_al !== e.al) begin
        fails++;
        $display("FAIL %s cyc=%0d: got pc=%h pc_plus=%h red=%b pend=%b al=%b, want pc=%h pc_plus=%h red=%b pend=%b al=%b",
                 e.nm, cyc, a_pc, a_pp, a_red, a_pend, a_al,
                 e.pc, e.pc + 32'd4, e.red, e.pend, e.al);
      end
    end
  end

  // Push the expectation for the state after the next edge, then take that edge.
  task automatic go(input string nm, input logic [31:0] epc,
                    input logic er, input logic ep, input logic ea);
    exp_t e;
    e.cyc = cyc + 1; e.which = 1'b0; e.pc = epc; e.red = er; e.pend = ep; e.al = ea; e.nm = nm;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Expectation for the wrap instance on the upcoming edge (call before go).
  task automatic exp2(input string nm, input logic [31:0] epc);
    exp_t e;
    e.cyc = cyc + 1; e.which = 1'b1; e.pc = epc; e.red = 1'b0; e.pend = 1'b0; e.al = 1'b0; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; jr = 0;
  endtask

  initial begin
    logic [31:0] mis_pc;
    reset = 1; reset2 = 1; idle();
    branch_base = 0; branch_offset = 0; jump_index = 0; jr_target = 0;

    go("reset", 32'h0, 0, 0, 0);
    reset = 0; reset2 = 0;
    go("seq4", 32'h4, 0, 0, 0);
    go("seq8", 32'h8, 0, 0, 0);
    go("seq12", 32'hC, 0, 0, 0);

    // Land on 0x100, then backward branch by two words.
    jr = 1; jr_target = 32'h100;
    go("jr_100", 32'h100, 1, 0, 0);
    idle(); branch_taken = 1; branch_base = 32'h104; branch_offset = 16'hFFFE;
    go("branch_back", 32'hFC, 1, 0, 0);
    idle();
    go("after_branch", 32'h100, 0, 0, 0);

    // Jump during stall is parked until release.
    stall = 1; jump = 1; branch_base = 32'h0040_0010; jump_index = 26'h10_0000;
    go("stall_jump", 32'h100, 0, 1, 0);
    jump = 0;
    for (int i = 0; i < 3; i++) go("stall_hold", 32'h100, 0, 1, 0);
    stall = 0;
    go("stall_release", 32'h0040_0000, 1, 0, 0);
    go("post_release", 32'h0040_0004, 0, 0, 0);

    // All three requests at once: jr wins.
    jr = 1; jump = 1; branch_taken = 1; jr_target = 32'h2000; branch_offset = 16'h0010;
    go("priority", 32'h2000, 1, 0, 0);

    // Newer parked request overwrites older one.
    idle(); stall = 1; branch_taken = 1; branch_base = 32'h3000; branch_offset = 16'h0001;
    go("park_branch", 32'h2000, 0, 1, 0);
    idle(); stall = 1; jr = 1; jr_target = 32'h5000;
    go("park_overwrite", 32'h2000, 0, 1, 0);
    idle(); stall = 1;
    go("park_hold", 32'h2000, 0, 1, 0);
    idle();
    go("park_replay", 32'h5000, 1, 0, 0);

    // Direct request at release beats the parked one.
    stall = 1; jr = 1; jr_target = 32'h6000;
    go("park_6000", 32'h5000, 0, 1, 0);
    idle(); branch_taken = 1; branch_base = 32'h100; branch_offset = 16'h0;
    go("new_beats_parked", 32'h100, 1, 0, 0);
    idle();
    go("seq_104", 32'h104, 0, 0, 0);

    // Misaligned jr target.
    jr = 1; jr_target = 32'h2002;
    mis_pc = ALIGN_ON ? 32'h80 : 32'h2002;
    go("misalign_jr", mis_pc, 1, 0, ALIGN_ON);
    idle();
    go("misalign_next", mis_pc + 32'd4, 0, 0, 0);

    // Misaligned target replayed from the parked slot.
    stall = 1; jr = 1; jr_target = 32'h3001;
    go("misalign_park", mis_pc + 32'd4, 0, 1, 0);
    idle();
    go("misalign_replay", ALIGN_ON ? 32'h80 : 32'h3001, 1, 0, ALIGN_ON);

    // Reset while stalled with a parked redirect discards it.
    stall = 1; jr = 1; jr_target = 32'h7000;
    go("park_7000", ALIGN_ON ? 32'h80 : 32'h3001, 0, 1, 0);
    jr = 0; reset = 1; reset2 = 1;
    exp2("wrap_reset", 32'hFFFF_FFF8);
    go("reset_in_stall", 32'h0, 0, 0, 0);
    reset = 0; reset2 = 0; stall = 0;
    exp2("wrap_fffc", 32'hFFFF_FFFC);
    go("no_stale_replay", 32'h4, 0, 0, 0);
    stall = 1;
    exp2("wrap_zero", 32'h0000_0000);
    go("plain_stall", 32'h4, 0, 0, 0);
    stall = 0;
    go("plain_release", 32'h8, 0, 0, 0);

    @(posedge clk); #1;
    @(negedge clk); #1;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations never checked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
